// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Holds the arbiter state encoding, default widths and the x0 index.
package rf_write_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int X0_IDX     = 0;

    typedef enum logic {
        ARB_NORMAL   = 1'b0,
        ARB_FAVOR_MC = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write bitmap: set on multi-cycle reservation, cleared on multi-cycle write.
// Updates at the next posedge; hazard lookup is combinational; never stalls.
module rf_scoreboard
    import rf_write_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_vld_i,
    input  logic [ADDR_W-1:0]    set_addr_i,
    input  logic                 clr_vld_i,
    input  logic [ADDR_W-1:0]    clr_addr_i,
    input  logic [ADDR_W-1:0]    chk_a1_i,
    input  logic [ADDR_W-1:0]    chk_a2_i,
    output logic [2**ADDR_W-1:0] busy_o,
    output logic                 hazard_o
);

    logic [2**ADDR_W-1:0] busy_q;
    logic [2**ADDR_W-1:0] busy_d;

    // Set is applied after clear so a same-cycle re-reservation survives.
    always_comb begin
        busy_d = busy_q;
        if (clr_vld_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_vld_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[X0_IDX] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o   = busy_q;
    assign hazard_o = busy_q[chk_a1_i] | busy_q[chk_a2_i];

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates writeback and multi-cycle writes onto one register-file write port.
// Zero latency (combinational grant); mc is forced after STARVE_LIMIT consecutive losses.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_valid,
    input  logic [ADDR_W-1:0]    wb_addr,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 wb_ready,
    input  logic                 mc_valid,
    input  logic [ADDR_W-1:0]    mc_addr,
    input  logic [DATA_W-1:0]    mc_data,
    output logic                 mc_ready,
    input  logic                 rsv_valid,
    input  logic [ADDR_W-1:0]    rsv_addr,
    input  logic [ADDR_W-1:0]    chk_a1,
    input  logic [ADDR_W-1:0]    chk_a2,
    output logic                 hazard,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_a3,
    output logic [DATA_W-1:0]    rf_wd,
    output logic [2**ADDR_W-1:0] busy
);

    localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             wb_grant, mc_grant;

    // Grants are gated by reset so nothing reaches the register file while held.
    always_comb begin
        wb_grant = rst & wb_valid & (state_q == ARB_NORMAL);
        mc_grant = rst & mc_valid & ((state_q == ARB_FAVOR_MC) | ~wb_valid);
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            ARB_NORMAL: begin
                if (mc_valid && !mc_grant) begin
                    if (starve_cnt_q == CNT_W'(STARVE_LIMIT - 1)) begin
                        state_d      = ARB_FAVOR_MC;
                        starve_cnt_d = '0;
                    end else begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end
                end else begin
                    starve_cnt_d = '0;
                end
            end
            ARB_FAVOR_MC: begin
                starve_cnt_d = '0;
                if (mc_grant) begin
                    state_d = ARB_NORMAL;
                end
            end
            default: begin
                state_d      = ARB_NORMAL;
                starve_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_NORMAL;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        rf_a3 = '0;
        rf_wd = '0;
        if (wb_grant) begin
            rf_a3 = wb_addr;
            rf_wd = wb_data;
        end else if (mc_grant) begin
            rf_a3 = mc_addr;
            rf_wd = mc_data;
        end
        rf_we = (wb_grant | mc_grant) & (rf_a3 != ADDR_W'(X0_IDX));
    end

    assign wb_ready = wb_grant;
    assign mc_ready = mc_grant;

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_vld_i  (rsv_valid),
        .set_addr_i (rsv_addr),
        .clr_vld_i  (mc_grant),
        .clr_addr_i (mc_addr),
        .chk_a1_i   (chk_a1),
        .chk_a2_i   (chk_a2),
        .busy_o     (busy),
        .hazard_o   (hazard)
    );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected grants go into a queue that a
// negedge monitor drains; bitmap/hazard/reset expectations are checked inline.
module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid, mc_valid, rsv_valid;
    logic [AW-1:0] wb_addr, mc_addr, rsv_addr, chk_a1, chk_a2;
    logic [DW-1:0] wb_data, mc_data;
    logic          wb_ready, mc_ready, hazard, rf_we;
    logic [AW-1:0] rf_a3;
    logic [DW-1:0] rf_wd;
    logic [2**AW-1:0] busy;

    typedef struct {
        bit            is_mc;
        bit            we;
        logic [AW-1:0] a3;
        logic [DW-1:0] wd;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready),
        .mc_valid  (mc_valid),
        .mc_addr   (mc_addr),
        .mc_data   (mc_data),
        .mc_ready  (mc_ready),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .chk_a1    (chk_a1),
        .chk_a2    (chk_a2),
        .hazard    (hazard),
        .rf_we     (rf_we),
        .rf_a3     (rf_a3),
        .rf_wd     (rf_wd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit is_mc, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.is_mc = is_mc;
        e.we    = we;
        e.a3    = a;
        e.wd    = d;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
        wb_valid = wv;
        wb_addr  = wa;
        wb_data  = wd;
        mc_valid = mv;
        mc_addr  = ma;
        mc_data  = md;
    endtask

    // Monitor: every accepted request must match the oldest expected grant.
    initial begin
        forever begin
            @(negedge clk);
            if (wb_ready || mc_ready) begin
                chk("single_grant", 64'(wb_ready & mc_ready), 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", 64'(rf_a3), 64'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("grant_port", 64'(mc_ready), 64'(e.is_mc));
                    chk("rf_we", 64'(rf_we), 64'(e.we));
                    chk("rf_a3", 64'(rf_a3), 64'(e.a3));
                    chk("rf_wd", 64'(rf_wd), 64'(e.wd));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        chk_a1    = '0;
        chk_a2    = '0;
        drive(1'b1, 5'd6, 32'h5, 1'b1, 5'd7, 32'h9);
        #2;
        chk("reset_wb_ready", 64'(wb_ready), 64'd0);
        chk("reset_mc_ready", 64'(mc_ready), 64'd0);
        chk("reset_rf_we", 64'(rf_we), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hazard", 64'(hazard), 64'd0);
        #5;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        #5;
        rst = 1'b1;

        // Plain writeback
        step();
        drive(1'b1, 5'd6, 32'h5, 1'b0, '0, '0);
        push(1'b0, 1'b1, 5'd6, 32'h5);
        @(negedge clk);
        chk("wb_only_ready", 64'(wb_ready), 64'd1);

        // Write to x0: accepted, not committed
        step();
        drive(1'b1, 5'd0, 32'hFF, 1'b0, '0, '0);
        push(1'b0, 1'b0, 5'd0, 32'hFF);
        @(negedge clk);
        chk("x0_rf_we", 64'(rf_we), 64'd0);

        // Reserve r8, observe hazard, then retire with an mc write
        step();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        rsv_valid = 1'b1;
        rsv_addr  = 5'd8;
        step();
        rsv_valid = 1'b0;
        chk_a1    = 5'd8;
        @(negedge clk);
        chk("rsv8_busy", 64'(busy[8]), 64'd1);
        chk("rsv8_hazard", 64'(hazard), 64'd1);
        step();
        drive(1'b0, '0, '0, 1'b1, 5'd8, 32'h2A);
        push(1'b1, 1'b1, 5'd8, 32'h2A);
        @(negedge clk);
        chk("mc8_hazard_still", 64'(hazard), 64'd1);
        step();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        chk("mc8_busy_clear", 64'(busy[8]), 64'd0);
        chk("mc8_hazard_clear", 64'(hazard), 64'd0);

        // Same-cycle set and clear of r3: set wins
        step();
        chk_a1    = '0;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd3;
        drive(1'b0, '0, '0, 1'b1, 5'd3, 32'h11);
        push(1'b1, 1'b1, 5'd3, 32'h11);
        step();
        rsv_valid = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        chk_a2 = 5'd3;
        @(negedge clk);
        chk("setclr_busy3", 64'(busy), 64'h8);
        chk("setclr_hazard", 64'(hazard), 64'd1);

        // Contention: wb wins 4 cycles, mc forced on the 5th, wb again on the 6th
        chk_a2 = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            drive(1'b1, AW'(10 + i), 32'h100 + 32'(i), 1'b1, 5'd20, 32'hABC);
            if (i == 4) begin
                push(1'b1, 1'b1, 5'd20, 32'hABC);
            end else begin
                push(1'b0, 1'b1, AW'(10 + i), 32'h100 + 32'(i));
            end
            @(negedge clk);
            if (i == 4) begin
                chk("favor_wb_ready", 64'(wb_ready), 64'd0);
            end
        end

        // Idle mc for a cycle, then starve it back into the forced state
        step();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b1, AW'(16 + i), 32'h200 + 32'(i), 1'b1, 5'd9, 32'h77);
            push(1'b0, 1'b1, AW'(16 + i), 32'h200 + 32'(i));
        end

        // Reset while the forced mc grant is pending
        step();
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h77);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_favor_mc_ready", 64'(mc_ready), 64'd0);
        chk("rst_favor_wb_ready", 64'(wb_ready), 64'd0);
        chk("rst_favor_rf_we", 64'(rf_we), 64'd0);
        chk("rst_favor_busy", 64'(busy), 64'd0);
        #2;
        rst = 1'b1;

        // Back in NORMAL: wb beats a concurrent mc request
        step();
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h77);
        push(1'b0, 1'b1, 5'd4, 32'h44);
        @(negedge clk);
        chk("post_rst_wb_ready", 64'(wb_ready), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);
        step();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        step();
        step();

        chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
